// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder
//   QSPI flash read responder running on the system clock. SCK, CS and DQ0 are
//   oversampled through 2-flop synchronizers; commands 0x03/0x0B/0x3B/0x6B are
//   served from an internal byte array that is preloaded through a backdoor.
// Ports
//   clk, rst            system clock (>= 8x SCK), async active-high reset
//   sck_i, csn_i, dq_i  QSPI pins from the host (mode 0, CS active low)
//   dq_o, dq_oe         QSPI data out and per-lane output enable
//   busy                CS low and a supported transaction is in progress
//   cmd_err             one-clk pulse on an unsupported command
//   ld_en/addr/data     backdoor byte write, honoured only while busy=0
module qspi_flash_responder #(
  parameter int MEM_DEPTH = 4096,
  parameter int ADDR_W    = 24,
  parameter int DUMMY_CYC = 8,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sck_i,
  input  logic          csn_i,
  input  logic [3:0]    dq_i,
  output logic [3:0]    dq_o,
  output logic [3:0]    dq_oe,
  output logic          busy,
  output logic          cmd_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data
);

  localparam int CNT_W = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  // Lane mapping of the next bit group taken from the top of the byte.
  function automatic logic [3:0] lane_bits(input logic [1:0] m, input logic [7:0] b);
    case (m)
      MODE_X2: return {2'b00, b[7:6]};
      MODE_X4: return b[7:4];
      default: return {2'b00, b[7], 1'b0};
    endcase
  endfunction

  function automatic logic [3:0] lane_oe(input logic [1:0] m);
    case (m)
      MODE_X2: return 4'b0011;
      MODE_X4: return 4'b1111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [3:0] lane_step(input logic [1:0] m);
    case (m)
      MODE_X2: return 4'd2;
      MODE_X4: return 4'd4;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic [7:0] byte_rest(input logic [1:0] m, input logic [7:0] b);
    case (m)
      MODE_X2: return {b[5:0], 2'b00};
      MODE_X4: return {b[3:0], 4'b0000};
      default: return {b[6:0], 1'b0};
    endcase
  endfunction

  logic [7:0]       mem [MEM_DEPTH];
  logic             sck_p0, sck_p1, sck_p2;
  logic             csn_p0, csn_p1, csn_p2;
  logic             dq0_p0, dq0_p1;
  logic [2:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [1:0]       mode;
  logic             use_dummy;
  logic [3:0]       out_cnt;
  logic [6:0]       cmd_sr;
  logic [AW-1:0]    addr_q;
  logic [7:0]       out_sr;
  logic             sck_rise, sck_fall, cs_fall, cs_high;
  logic [7:0]       cmd_byte;
  logic [7:0]       cur_byte;
  logic             unused_dq_hi;

  assign unused_dq_hi = ^dq_i[3:1];

  // Stage p0/p1: synchronizers; p2 holds the previous synchronized level for
  // edge detection. CS resets low so a CS held low across reset never looks
  // like a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_p0 <= 1'b0; sck_p1 <= 1'b0; sck_p2 <= 1'b0;
      csn_p0 <= 1'b0; csn_p1 <= 1'b0; csn_p2 <= 1'b0;
      dq0_p0 <= 1'b0; dq0_p1 <= 1'b0;
    end else begin
      sck_p0 <= sck_i;    sck_p1 <= sck_p0; sck_p2 <= sck_p1;
      csn_p0 <= csn_i;    csn_p1 <= csn_p0; csn_p2 <= csn_p1;
      dq0_p0 <= dq_i[0];  dq0_p1 <= dq0_p0;
    end
  end

  assign sck_rise = sck_p1 & ~sck_p2;
  assign sck_fall = ~sck_p1 & sck_p2;
  assign cs_fall  = ~csn_p1 & csn_p2;
  assign cs_high  = csn_p1;
  assign cmd_byte = {cmd_sr, dq0_p1};
  // A new byte is fetched from the array whenever the previous one is fully shifted.
  assign cur_byte = (out_cnt == 4'd0) ? mem[addr_q] : out_sr;
  assign busy     = (state == ST_CMD) || (state == ST_ADDR) ||
                    (state == ST_DUMMY) || (state == ST_DATA);

  // Stage p2 -> outputs: protocol FSM and output lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      mode      <= MODE_X1;
      use_dummy <= 1'b0;
      out_cnt   <= 4'd0;
      cmd_err   <= 1'b0;
      dq_o      <= 4'd0;
      dq_oe     <= 4'd0;
    end else begin
      cmd_err <= 1'b0;
      if (state != ST_IDLE && cs_high) begin
        state <= ST_IDLE;
        dq_o  <= 4'd0;
        dq_oe <= 4'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(7)) begin
                bit_cnt <= '0;
                state   <= ST_ADDR;
                case (cmd_byte)
                  8'h03: begin mode <= MODE_X1; use_dummy <= 1'b0; end
                  8'h0B: begin mode <= MODE_X1; use_dummy <= (DUMMY_CYC > 0); end
                  8'h3B: begin mode <= MODE_X2; use_dummy <= (DUMMY_CYC > 0); end
                  8'h6B: begin mode <= MODE_X4; use_dummy <= (DUMMY_CYC > 0); end
                  default: begin
                    state   <= ST_IGNORE;
                    cmd_err <= 1'b1;
                  end
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                bit_cnt <= '0;
                out_cnt <= 4'd0;
                state   <= use_dummy ? ST_DUMMY : ST_DATA;
              end
            end
          end
          ST_DUMMY: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(DUMMY_CYC - 1)) begin
                bit_cnt <= '0;
                out_cnt <= 4'd0;
                state   <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sck_fall) begin
              dq_o    <= lane_bits(mode, cur_byte);
              dq_oe   <= lane_oe(mode);
              out_cnt <= ((out_cnt == 4'd0) ? 4'd8 : out_cnt) - lane_step(mode);
            end
          end
          ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Datapath shift registers; no reset needed, every use is qualified by state.
  always_ff @(posedge clk) begin
    if (state == ST_CMD && sck_rise)
      cmd_sr <= {cmd_sr[5:0], dq0_p1};
    if (state == ST_ADDR && sck_rise)
      addr_q <= {addr_q[AW-2:0], dq0_p1};
    else if (state == ST_DATA && sck_fall && out_cnt == 4'd0)
      addr_q <= addr_q + AW'(1);
    if (state == ST_DATA && sck_fall)
      out_sr <= byte_rest(mode, cur_byte);
  end

  always_ff @(posedge clk) begin
    if (ld_en && !busy)
      mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Testbench for qspi_flash_responder: drives QSPI reads as a host would,
// keeps a byte-array model of the flash, and scoreboards lane values.
module tb_qspi_flash_responder;

  localparam int H     = 8;
  localparam int DUMMY = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck_i, csn_i;
  logic [3:0]  dq_i;
  logic [3:0]  dq_o, dq_oe;
  logic        busy, cmd_err;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [7:0]  ld_data;

  typedef struct {
    logic [3:0] dq;
    logic [3:0] mask;
    logic [3:0] oe;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] tb_mem [4096];
  int         total = 0;
  int         bad   = 0;
  int         err_cnt = 0;
  int         err_base;

  qspi_flash_responder #(.MEM_DEPTH(4096), .ADDR_W(24), .DUMMY_CYC(DUMMY)) dut (
    .clk(clk), .rst(rst), .sck_i(sck_i), .csn_i(csn_i), .dq_i(dq_i),
    .dq_o(dq_o), .dq_oe(dq_oe), .busy(busy), .cmd_err(cmd_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_err === 1'b1) err_cnt <= err_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [7:0] d, input bit accept);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    if (accept) tb_mem[a] = d;
  endtask

  task automatic tick(input logic b);
    dq_i[0] = b;
    repeat (H) @(negedge clk);
    sck_i = 1'b1;
    repeat (H) @(negedge clk);
    sck_i = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tick(v[i]);
  endtask

  task automatic begin_cs();
    csn_i = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic end_cs();
    repeat (2) @(negedge clk);
    csn_i = 1'b1;
    sck_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("oe_after_cs", 8'(dq_oe), 8'h00);
    chk("busy_after_cs", 8'(busy), 8'h00);
  endtask

  function automatic exp_t make_exp(input logic [7:0] cmd, input logic [11:0] a, input int k);
    exp_t e;
    int w, per, sh;
    logic [11:0] idx;
    logic [7:0] b;
    logic [3:0] g, m;
    w   = (cmd == 8'h6B) ? 4 : (cmd == 8'h3B) ? 2 : 1;
    per = 8 / w;
    idx = 12'(int'(a) + k / per);
    b   = tb_mem[idx];
    sh  = 8 - w * (k % per + 1);
    m   = (w == 4) ? 4'hF : (w == 2) ? 4'h3 : 4'h1;
    g   = 4'(b >> sh) & m;
    if (w == 1) begin
      e.dq = {2'b00, g[0], 1'b0}; e.mask = 4'b0010; e.oe = 4'b0010;
    end else if (w == 2) begin
      e.dq = g; e.mask = 4'b0011; e.oe = 4'b0011;
    end else begin
      e.dq = g; e.mask = 4'b1111; e.oe = 4'b1111;
    end
    return e;
  endfunction

  task automatic read_steps(input logic [7:0] cmd, input logic [11:0] a, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) sb_q.push_back(make_exp(cmd, a, k));
    for (int k = 0; k < n; k++) begin
      repeat (H) @(negedge clk);
      e = sb_q.pop_front();
      chk("data_lanes", 8'(dq_o & e.mask), 8'(e.dq));
      chk("data_oe", 8'(dq_oe), 8'(e.oe));
      sck_i = 1'b1;
      repeat (H) @(negedge clk);
      sck_i = 1'b0;
    end
  endtask

  task automatic head(input logic [7:0] cmd, input logic [23:0] a);
    send_bits(32'(cmd), 8);
    chk("busy_in_cmd", 8'(busy), 8'h01);
    send_bits(32'(a), 24);
    if (cmd != 8'h03) begin
      for (int i = 0; i < DUMMY; i++) begin
        tick(1'b0);
        if (i < DUMMY - 1) chk("oe_in_dummy", 8'(dq_oe), 8'h00);
      end
    end
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [23:0] a, input int n);
    begin_cs();
    head(cmd, a);
    read_steps(cmd, a[11:0], n);
    end_cs();
  endtask

  initial begin
    rst = 1'b1; sck_i = 1'b0; csn_i = 1'b1; dq_i = 4'h0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_dq_o", 8'(dq_o), 8'h00);
    chk("rst_dq_oe", 8'(dq_oe), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_cmd_err", 8'(cmd_err), 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    load(12'h010, 8'hA5, 1); load(12'h011, 8'h5A, 1);
    load(12'h012, 8'hC3, 1); load(12'h013, 8'h3C, 1);
    load(12'hFFF, 8'h96, 1); load(12'h000, 8'h81, 1);
    load(12'h020, 8'hE1, 1); load(12'h030, 8'hAA, 1);

    // single read of four bytes on dq1
    do_read(8'h03, 24'h000010, 32);
    // quad read with dummy cycles
    do_read(8'h6B, 24'h000012, 4);
    // dual read wrapping the top of the array
    do_read(8'h3B, 24'h000FFF, 8);
    // fast read with address above MEM_DEPTH (modulo)
    do_read(8'h0B, 24'h123013, 8);

    // abort after 3 data bits, then backdoor write and read back
    do_read(8'h03, 24'h000020, 3);
    load(12'h020, 8'h77, 1);
    do_read(8'h03, 24'h000020, 8);

    // backdoor write while busy must be ignored
    begin_cs();
    send_bits(32'h03, 8);
    chk("busy_before_ld", 8'(busy), 8'h01);
    load(12'h030, 8'h55, 0);
    send_bits(32'h000030, 24);
    read_steps(8'h03, 12'h030, 8);
    end_cs();

    // CS fall coincident with a backdoor write
    ld_addr = 12'h050; ld_data = 8'h3D; ld_en = 1'b1; csn_i = 1'b0;
    @(negedge clk);
    ld_en = 1'b0;
    tb_mem[12'h050] = 8'h3D;
    repeat (H - 1) @(negedge clk);
    head(8'h03, 24'h000050);
    read_steps(8'h03, 12'h050, 8);
    end_cs();

    // unsupported command
    err_base = err_cnt;
    begin_cs();
    send_bits(32'h9F, 8);
    repeat (4) @(negedge clk);
    chk("cmd_err_pulses", 8'(err_cnt - err_base), 8'h01);
    chk("busy_ignore", 8'(busy), 8'h00);
    load(12'h040, 8'h66, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      chk("oe_ignore", 8'(dq_oe), 8'h00);
    end
    chk("cmd_err_single", 8'(err_cnt - err_base), 8'h01);
    end_cs();
    do_read(8'h03, 24'h000040, 8);

    // reset asserted with CS low mid-read
    begin_cs();
    head(8'h03, 24'h000010);
    read_steps(8'h03, 12'h010, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_oe", 8'(dq_oe), 8'h00);
    chk("midrst_busy", 8'(busy), 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("postrst_busy", 8'(busy), 8'h00);
    csn_i = 1'b1;
    repeat (6) @(negedge clk);
    do_read(8'h03, 24'h000011, 8);

    chk("cmd_err_total", 8'(err_cnt), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
